// File: rtl/decode_stage.sv
// RV32I decode stage: IF/ID register, 32x32 register file with write-through
// bypass, immediate generation, control decode and the ID/EX register.
module decode_stage #(
   parameter logic [31:0] NOP_INSTR          = 32'h0000_0013,
   parameter bit          ZERO_REG_HARDWIRED = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_decode,
   input  logic        flush_decode,
   input  logic        flush_execute,
   input  logic [31:0] instruction_fetch,
   input  logic [31:0] pc_fetch,
   input  logic [31:0] next_pc_fetch,
   input  logic        reg_write_wb,
   input  logic [4:0]  rd_wb,
   input  logic [31:0] result_wb,
   output logic [31:0] rd1_execute,
   output logic [31:0] rd2_execute,
   output logic [31:0] imm_ext_execute,
   output logic [4:0]  rs1_execute,
   output logic [4:0]  rs2_execute,
   output logic [4:0]  rd_execute,
   output logic [31:0] pc_execute,
   output logic [31:0] next_pc_execute,
   output logic [3:0]  alu_control_execute,
   output logic        alu_src_execute,
   output logic [1:0]  result_src_execute,
   output logic        reg_write_execute,
   output logic        mem_write_execute,
   output logic        branch_execute,
   output logic        jump_execute,
   output logic        jalr_execute,
   output logic        illegal_execute
);

   localparam int unsigned XLEN   = 32;
   localparam int unsigned REG_AW = 5;
   localparam int unsigned NREGS  = 32;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [3:0] ALU_ADD    = 4'd0;
   localparam logic [3:0] ALU_SUB    = 4'd1;
   localparam logic [3:0] ALU_AND    = 4'd2;
   localparam logic [3:0] ALU_OR     = 4'd3;
   localparam logic [3:0] ALU_XOR    = 4'd4;
   localparam logic [3:0] ALU_SLL    = 4'd5;
   localparam logic [3:0] ALU_SRL    = 4'd6;
   localparam logic [3:0] ALU_SRA    = 4'd7;
   localparam logic [3:0] ALU_SLT    = 4'd8;
   localparam logic [3:0] ALU_SLTU   = 4'd9;
   localparam logic [3:0] ALU_PASS_B = 4'd10;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef struct packed {
      logic [XLEN-1:0]   rd1;
      logic [XLEN-1:0]   rd2;
      logic [XLEN-1:0]   imm;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   pc;
      logic [XLEN-1:0]   pc4;
      logic [3:0]        alu_control;
      logic              alu_src;
      logic [1:0]        result_src;
      logic              reg_write;
      logic              mem_write;
      logic              branch;
      logic              jump;
      logic              jalr;
      logic              illegal;
   } idex_t;

   logic [XLEN-1:0]   instr_d;
   logic [XLEN-1:0]   pc_d;
   logic [XLEN-1:0]   pc4_d;
   logic [XLEN-1:0]   regs [NREGS];
   logic [6:0]        opcode;
   logic [2:0]        funct3;
   logic [6:0]        funct7;
   logic [REG_AW-1:0] rs1_f;
   logic [REG_AW-1:0] rs2_f;
   logic [REG_AW-1:0] rd_f;
   logic              wb_en;
   logic [XLEN-1:0]   rd1_c;
   logic [XLEN-1:0]   rd2_c;
   logic [XLEN-1:0]   imm_c;
   idex_t             dec_c;
   idex_t             idex_q;

   assign opcode = instr_d[6:0];
   assign rd_f   = instr_d[11:7];
   assign funct3 = instr_d[14:12];
   assign rs1_f  = instr_d[19:15];
   assign rs2_f  = instr_d[24:20];
   assign funct7 = instr_d[31:25];

   // IF/ID register: flush beats stall beats load
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         instr_d <= NOP_INSTR;
         pc_d    <= '0;
         pc4_d   <= '0;
      end else if (flush_decode) begin
         instr_d <= NOP_INSTR;
         pc_d    <= '0;
         pc4_d   <= '0;
      end else if (!stall_decode) begin
         instr_d <= instruction_fetch;
         pc_d    <= pc_fetch;
         pc4_d   <= next_pc_fetch;
      end
   end

   assign wb_en = reg_write_wb && (!ZERO_REG_HARDWIRED || (rd_wb != '0));

   // Register file storage; the whole array clears on reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (wb_en) begin
         regs[rd_wb] <= result_wb;
      end
   end

   // Combinational reads with same-cycle write-through
   always_comb begin
      rd1_c = regs[rs1_f];
      rd2_c = regs[rs2_f];
      if (wb_en && (rd_wb == rs1_f)) rd1_c = result_wb;
      if (wb_en && (rd_wb == rs2_f)) rd2_c = result_wb;
      if (ZERO_REG_HARDWIRED && (rs1_f == '0)) rd1_c = '0;
      if (ZERO_REG_HARDWIRED && (rs2_f == '0)) rd2_c = '0;
   end

   always_comb begin
      imm_c = '0;
      case (opcode)
         OP_IMM, OP_LOAD, OP_JALR: imm_c = {{20{instr_d[31]}}, instr_d[31:20]};
         OP_STORE:  imm_c = {{20{instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
         OP_BRANCH: imm_c = {{19{instr_d[31]}}, instr_d[31], instr_d[7],
                             instr_d[30:25], instr_d[11:8], 1'b0};
         OP_LUI, OP_AUIPC: imm_c = {instr_d[31:12], 12'b0};
         OP_JAL:    imm_c = {{11{instr_d[31]}}, instr_d[31], instr_d[19:12],
                             instr_d[20], instr_d[30:21], 1'b0};
         default:   imm_c = '0;
      endcase
   end

   // Control decode; an unsupported encoding drops every control and raises illegal
   always_comb begin
      logic legal;
      dec_c     = '0;
      legal     = 1'b1;
      dec_c.rd1 = rd1_c;
      dec_c.rd2 = rd2_c;
      dec_c.imm = imm_c;
      dec_c.rs1 = rs1_f;
      dec_c.rs2 = rs2_f;
      dec_c.pc  = pc_d;
      dec_c.pc4 = pc4_d;
      case (opcode)
         OP_R: begin
            dec_c.reg_write = 1'b1;
            if ((funct7 != F7_BASE) &&
                !((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101))))
               legal = 1'b0;
            case (funct3)
               3'b000:  dec_c.alu_control = funct7[5] ? ALU_SUB : ALU_ADD;
               3'b001:  dec_c.alu_control = ALU_SLL;
               3'b010:  dec_c.alu_control = ALU_SLT;
               3'b011:  dec_c.alu_control = ALU_SLTU;
               3'b100:  dec_c.alu_control = ALU_XOR;
               3'b101:  dec_c.alu_control = funct7[5] ? ALU_SRA : ALU_SRL;
               3'b110:  dec_c.alu_control = ALU_OR;
               default: dec_c.alu_control = ALU_AND;
            endcase
         end
         OP_IMM: begin
            dec_c.reg_write = 1'b1;
            dec_c.alu_src   = 1'b1;
            case (funct3)
               3'b000:  dec_c.alu_control = ALU_ADD;
               3'b001: begin
                  dec_c.alu_control = ALU_SLL;
                  if (funct7 != F7_BASE) legal = 1'b0;
               end
               3'b010:  dec_c.alu_control = ALU_SLT;
               3'b011:  dec_c.alu_control = ALU_SLTU;
               3'b100:  dec_c.alu_control = ALU_XOR;
               3'b101: begin
                  dec_c.alu_control = funct7[5] ? ALU_SRA : ALU_SRL;
                  if ((funct7 != F7_BASE) && (funct7 != F7_ALT)) legal = 1'b0;
               end
               3'b110:  dec_c.alu_control = ALU_OR;
               default: dec_c.alu_control = ALU_AND;
            endcase
         end
         OP_LOAD: begin
            dec_c.alu_src    = 1'b1;
            dec_c.result_src = 2'b01;
            dec_c.reg_write  = 1'b1;
            if ((funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111))
               legal = 1'b0;
         end
         OP_STORE: begin
            dec_c.alu_src   = 1'b1;
            dec_c.mem_write = 1'b1;
            if (funct3 > 3'b010) legal = 1'b0;
         end
         OP_BRANCH: begin
            dec_c.alu_control = ALU_SUB;
            dec_c.branch      = 1'b1;
            if ((funct3 == 3'b010) || (funct3 == 3'b011)) legal = 1'b0;
         end
         OP_LUI: begin
            dec_c.alu_control = ALU_PASS_B;
            dec_c.alu_src     = 1'b1;
            dec_c.reg_write   = 1'b1;
         end
         OP_AUIPC: begin
            dec_c.alu_src   = 1'b1;
            dec_c.reg_write = 1'b1;
         end
         OP_JAL: begin
            dec_c.jump       = 1'b1;
            dec_c.result_src = 2'b10;
            dec_c.reg_write  = 1'b1;
         end
         OP_JALR: begin
            dec_c.jalr       = 1'b1;
            dec_c.jump       = 1'b1;
            dec_c.alu_src    = 1'b1;
            dec_c.result_src = 2'b10;
            dec_c.reg_write  = 1'b1;
            if (funct3 != 3'b000) legal = 1'b0;
         end
         default: legal = 1'b0;
      endcase
      if (!legal) begin
         dec_c.alu_control = '0;
         dec_c.alu_src     = 1'b0;
         dec_c.result_src  = '0;
         dec_c.reg_write   = 1'b0;
         dec_c.mem_write   = 1'b0;
         dec_c.branch      = 1'b0;
         dec_c.jump        = 1'b0;
         dec_c.jalr        = 1'b0;
         dec_c.illegal     = 1'b1;
      end
      dec_c.rd = dec_c.reg_write ? rd_f : '0;
   end

   // ID/EX register: flush inserts an all-zero bubble
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)               idex_q <= '0;
      else if (flush_execute) idex_q <= '0;
      else                    idex_q <= dec_c;
   end

   assign rd1_execute         = idex_q.rd1;
   assign rd2_execute         = idex_q.rd2;
   assign imm_ext_execute     = idex_q.imm;
   assign rs1_execute         = idex_q.rs1;
   assign rs2_execute         = idex_q.rs2;
   assign rd_execute          = idex_q.rd;
   assign pc_execute          = idex_q.pc;
   assign next_pc_execute     = idex_q.pc4;
   assign alu_control_execute = idex_q.alu_control;
   assign alu_src_execute     = idex_q.alu_src;
   assign result_src_execute  = idex_q.result_src;
   assign reg_write_execute   = idex_q.reg_write;
   assign mem_write_execute   = idex_q.mem_write;
   assign branch_execute      = idex_q.branch;
   assign jump_execute        = idex_q.jump;
   assign jalr_execute        = idex_q.jalr;
   assign illegal_execute     = idex_q.illegal;

endmodule
